// File: rtl/sop_eval_prog.sv
// sop_eval_prog -- programmable, registered sum-of-products evaluator.
//
// Each of N_TERMS product terms has a care mask, a polarity mask and an
// enable bit. Terms are written at run time through the cfg_* port.
// The function is f = OR of all terms. Input vectors stream through with
// one cycle of latency. A built-in sweep walks every 2^N_IN input vector,
// counts the vectors with f=1 and reports the count on minterm_cnt.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   cfg_we/idx        term write strobe and term index (IDLE only)
//   cfg_care/pol/en   new care mask, polarity mask and enable for the term
//   in_valid/in_vec   streamed input vector (IDLE only)
//   sweep_start       start an exhaustive sweep (IDLE only)
//   out_valid         result valid; out_f/out_terms/out_vec hold otherwise
//   out_f/out_terms   function value and per-term values
//   out_vec           vector that produced the result
//   sweep_busy        sweep in progress (RUN or DONE)
//   sweep_done        one-cycle pulse when the sweep finishes
//   minterm_cnt       count of f=1 vectors in the last completed sweep
module sop_eval_prog #(
  parameter int N_IN    = 5,
  parameter int N_TERMS = 6,
  parameter int IW      = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_pol,
  input  logic               cfg_en,
  input  logic               in_valid,
  input  logic [N_IN-1:0]    in_vec,
  input  logic               sweep_start,
  output logic               out_valid,
  output logic               out_f,
  output logic [N_TERMS-1:0] out_terms,
  output logic [N_IN-1:0]    out_vec,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic [N_IN:0]      minterm_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  // Term configuration
  logic [N_IN-1:0]    care_q [N_TERMS];
  logic [N_IN-1:0]    pol_q  [N_TERMS];
  logic [N_TERMS-1:0] en_q;

  // Sweep control and result registers
  logic [1:0]         state_q,     state_d;
  logic [N_IN-1:0]    cnt_q,       cnt_d;
  logic [N_IN:0]      acc_q,       acc_d;
  logic [N_IN:0]      mcnt_q,      mcnt_d;
  logic               done_q,      done_d;
  logic               out_valid_q, out_valid_d;
  logic               out_f_q,     out_f_d;
  logic [N_TERMS-1:0] out_terms_q, out_terms_d;
  logic [N_IN-1:0]    out_vec_q,   out_vec_d;

  // Evaluator datapath
  logic [N_IN-1:0]    eval_vec;
  logic [N_TERMS-1:0] term_val;
  logic               f_val;
  logic               eval_fire;
  logic               cfg_ok;

  // Config is locked outside IDLE; out-of-range indices are dropped.
  assign cfg_ok = cfg_we && (state_q == S_IDLE) && (int'(cfg_idx) < N_TERMS);

  // NOTE: the term table is a handful of flops, not a RAM, so it can and
  // must be cleared by reset; a real memory macro would not allow this.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_TERMS; t++) begin
        care_q[t] <= '0;
        pol_q[t]  <= '0;
      end
      en_q <= '0;
    end else if (cfg_ok) begin
      care_q[cfg_idx] <= cfg_care;
      pol_q[cfg_idx]  <= cfg_pol;
      en_q[cfg_idx]   <= cfg_en;
    end
  end

  // The sweep counter replaces the streamed vector while running. A write
  // in the same cycle lands at the edge, so this vector still sees the
  // old config.
  assign eval_vec  = (state_q == S_RUN) ? cnt_q : in_vec;
  assign eval_fire = (state_q == S_RUN) || ((state_q == S_IDLE) && in_valid);

  // A bit matches when it equals its polarity or is a don't-care.
  always_comb begin
    for (int t = 0; t < N_TERMS; t++) begin
      term_val[t] = en_q[t] & (&(~(eval_vec ^ pol_q[t]) | ~care_q[t]));
    end
  end

  assign f_val = |term_val;

  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcnt_d      = mcnt_q;
    done_d      = 1'b0;
    out_valid_d = eval_fire;
    out_f_d     = out_f_q;
    out_terms_d = out_terms_q;
    out_vec_d   = out_vec_q;

    if (eval_fire) begin
      out_f_d     = f_val;
      out_terms_d = term_val;
      out_vec_d   = eval_vec;
    end

    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        if (f_val) acc_d = acc_q + (N_IN+1)'(1);
        // Counter stops on the last vector rather than wrapping.
        if (cnt_q == VEC_LAST) state_d = S_DONE;
        else                   cnt_d   = cnt_q + N_IN'(1);
      end
      S_DONE: begin
        // The last result is on the outputs now; publish the final count.
        state_d = S_IDLE;
        mcnt_d  = acc_q;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcnt_q      <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_f_q     <= 1'b0;
      out_terms_q <= '0;
      out_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcnt_q      <= mcnt_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
      out_terms_q <= out_terms_d;
      out_vec_q   <= out_vec_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_f       = out_f_q;
  assign out_terms   = out_terms_q;
  assign out_vec     = out_vec_q;
  assign sweep_busy  = (state_q != S_IDLE);
  assign sweep_done  = done_q;
  assign minterm_cnt = mcnt_q;

endmodule

// File: tb/tb_sop_eval_prog.sv
// tb_sop_eval_prog -- scoreboard bench for sop_eval_prog (N_IN=5, N_TERMS=6).
// Stimulus pushes expected results into a queue; a negedge monitor pops and
// compares whenever out_valid is high. Expected term values come from the
// six-term function written out directly as boolean expressions.
module tb_sop_eval_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [4:0] cfg_care;
  logic [4:0] cfg_pol;
  logic       cfg_en;
  logic       in_valid;
  logic [4:0] in_vec;
  logic       sweep_start;
  logic       out_valid;
  logic       out_f;
  logic [5:0] out_terms;
  logic [4:0] out_vec;
  logic       sweep_busy;
  logic       sweep_done;
  logic [5:0] minterm_cnt;

  sop_eval_prog #(.N_IN(5), .N_TERMS(6)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_care(cfg_care),
    .cfg_pol(cfg_pol), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_vec(in_vec), .sweep_start(sweep_start),
    .out_valid(out_valid), .out_f(out_f), .out_terms(out_terms),
    .out_vec(out_vec), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .minterm_cnt(minterm_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] vec;
    logic       f;
    logic [5:0] terms;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: which of the six terms are live, or the
  // single always-true term 0.
  logic [5:0] model_en   = 6'h00;
  logic       model_taut = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // X'Y'M', X'YKM, Y'Z'K, X'Z'K, XY'M, XZ'M with {X,Y,Z,K,M} = vec[4:0]
  function automatic logic [5:0] six_terms(input logic [4:0] v);
    logic x, y, z, k, m;
    logic [5:0] r;
    {x, y, z, k, m} = v;
    r[0] = ~x & ~y & ~m;
    r[1] = ~x &  y &  k & m;
    r[2] = ~y & ~z &  k;
    r[3] = ~x & ~z &  k;
    r[4] =  x & ~y &  m;
    r[5] =  x & ~z &  m;
    return r;
  endfunction

  function automatic exp_t expect_for(input logic [4:0] v);
    exp_t e;
    e.vec   = v;
    e.terms = model_taut ? 6'b000001 : (six_terms(v) & model_en);
    e.f     = |e.terms;
    return e;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out_valid: got vec=0x%0h f=%0b with none expected at %0t",
                 out_vec, out_f, $time);
      end else begin
        mon_e = sb.pop_front();
        check("result{vec,f,terms}", {out_vec, out_f, out_terms}, mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [4:0] care,
                           input logic [4:0] pol, input logic en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_care = care; cfg_pol = pol; cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic program_six();
    cfg_write(3'd0, 5'b11001, 5'b00000, 1'b1);
    cfg_write(3'd1, 5'b11011, 5'b01011, 1'b1);
    cfg_write(3'd2, 5'b01110, 5'b00010, 1'b1);
    cfg_write(3'd3, 5'b10110, 5'b00010, 1'b1);
    cfg_write(3'd4, 5'b11001, 5'b10001, 1'b1);
    cfg_write(3'd5, 5'b10101, 5'b10001, 1'b1);
    model_en   = 6'h3f;
    model_taut = 1'b0;
  endtask

  task automatic stream(input logic [4:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    sb.push_back(expect_for(v));
    tick();
  endtask

  // Full sweep; optionally pokes a config write and a stray in_valid into
  // the RUN window, both of which must be ignored.
  task automatic run_sweep(input int exp_cnt, input bit poke);
    int cycles;
    bit seen;
    sweep_start = 1'b1;
    for (int i = 0; i < 32; i++) sb.push_back(expect_for(5'(i)));
    tick();
    sweep_start = 1'b0;
    check("sweep_busy_after_start", sweep_busy, 1);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 100) begin
      if (poke && cycles == 3) begin in_valid = 1'b1; in_vec = 5'b11111; end
      if (poke && cycles == 4) in_valid = 1'b0;
      if (poke && cycles == 5) begin
        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_care = 5'b00000; cfg_pol = 5'b00000; cfg_en = 1'b1;
      end
      if (poke && cycles == 6) cfg_we = 1'b0;
      tick();
      cycles++;
      seen = sweep_done;
    end
    check("sweep_done_latency", cycles, 33);
    check("minterm_cnt", minterm_cnt, exp_cnt);
    check("sweep_busy_cleared", sweep_busy, 0);
    check("sweep_results_drained", sb.size(), 0);
    tick();
    check("sweep_done_one_cycle", sweep_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_care = '0; cfg_pol = '0; cfg_en = 1'b0;
    in_valid = 1'b0; in_vec = '0; sweep_start = 1'b0;
    repeat (2) tick();
    check("rst_out_valid",   out_valid,   0);
    check("rst_out_f",       out_f,       0);
    check("rst_out_terms",   out_terms,   0);
    check("rst_out_vec",     out_vec,     0);
    check("rst_sweep_busy",  sweep_busy,  0);
    check("rst_sweep_done",  sweep_done,  0);
    check("rst_minterm_cnt", minterm_cnt, 0);
    rst = 1'b0;
    tick();

    // Cleared config: everything evaluates to 0.
    stream(5'b10101);
    in_valid = 1'b0;
    repeat (2) tick();
    check("minterm_cnt_idle", minterm_cnt, 0);

    // Six-term function, back-to-back vectors: f = 1, 0, 1.
    program_six();
    stream(5'b00000);
    stream(5'b11111);
    stream(5'b01011);
    in_valid = 1'b0;
    repeat (2) tick();

    // Out-of-range index must not alias onto a real term.
    cfg_write(3'd7, 5'b00000, 5'b00000, 1'b1);
    cfg_write(3'd6, 5'b00000, 5'b00000, 1'b1);
    stream(5'b11111);
    in_valid = 1'b0;
    tick();

    // Sweep with config write and stray in_valid during RUN.
    run_sweep(15, 1'b1);

    // Same-cycle write and vector: old config now, new config next cycle.
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_care = 5'b11001; cfg_pol = 5'b00000; cfg_en = 1'b0;
    stream(5'b00000);
    cfg_we = 1'b0;
    model_en[0] = 1'b0;
    stream(5'b00000);
    in_valid = 1'b0;
    cfg_write(3'd0, 5'b11001, 5'b00000, 1'b1);
    model_en[0] = 1'b1;
    tick();

    // Term 0 enabled with no cared inputs, others disabled: tautology.
    cfg_write(3'd0, 5'b00000, 5'b00000, 1'b1);
    for (int t = 1; t < 6; t++) cfg_write(3'(t), 5'b00000, 5'b00000, 1'b0);
    model_taut = 1'b1;
    run_sweep(32, 1'b0);

    // All terms disabled.
    cfg_write(3'd0, 5'b00000, 5'b00000, 1'b0);
    model_taut = 1'b0;
    model_en   = 6'h00;
    run_sweep(0, 1'b0);

    // Six terms again, then abort a sweep with reset at counter = 10.
    program_six();
    run_sweep(15, 1'b0);
    sweep_start = 1'b1;
    for (int i = 0; i < 10; i++) sb.push_back(expect_for(5'(i)));
    tick();
    sweep_start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_en = 6'h00;
    check("abort_out_valid",   out_valid,   0);
    check("abort_out_f",       out_f,       0);
    check("abort_out_terms",   out_terms,   0);
    check("abort_out_vec",     out_vec,     0);
    check("abort_sweep_busy",  sweep_busy,  0);
    check("abort_minterm_cnt", minterm_cnt, 0);
    check("abort_results_drained", sb.size(), 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("abort_no_sweep_done", sweep_done, 0);
    end

    // Config was cleared by the reset.
    run_sweep(0, 1'b0);

    repeat (3) tick();
    check("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
